// File: rtl/div_iter_pkg.sv
// Shared types for the iterative divider: FSM state encoding and the ex-side request bundle.
// No logic here, so no latency.
// No handshake of its own.
package div_iter_pkg;

    // Native datapath width of the core that feeds the divider
    localparam int DIV_XLEN = 32;

    // Divider control states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    // Request bundle used by the execute stage when it routes operands to the divider
    typedef struct packed {
        logic                sign;
        logic [DIV_XLEN-1:0] srca;
        logic [DIV_XLEN-1:0] srcb;
    } dp_div_req_t;

endpackage : div_iter_pkg

// File: rtl/div_iter_if.sv
// Request/response bundle between the execute stage and the divider.
// Pure wiring, zero latency.
// valid/ready on both the request side and the result side.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    // request side
    logic             in_valid;
    logic             in_ready;
    logic             sign;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    // result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    // Execute stage: issues requests and consumes results
    modport master (
        output in_valid, sign, srca, srcb, out_ready,
        input  in_ready, out_valid, hi, lo, div_zero
    );

    // Divider: accepts requests and produces results
    modport slave (
        input  in_valid, sign, srca, srcb, out_ready,
        output in_ready, out_valid, hi, lo, div_zero
    );
endinterface : div_iter_if

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step on {rem,quo} against an unsigned divisor.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is registered.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   sh_rem;
    logic [WIDTH+1:0] diff;
    logic             unused_diff_top;

    // Shift {rem,quo} left by one and trial-subtract the divisor; keep the difference when no borrow
    always_comb begin
        sh_rem = {rem_i, quo_i[WIDTH-1]};
        diff   = {1'b0, sh_rem} - {2'b00, dvs_i};
        if (!diff[WIDTH+1]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = sh_rem[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

    // A kept difference is always below the divisor, so its bit WIDTH is zero and never needed
    assign unused_diff_top = diff[WIDTH];

endmodule : div_iter_step

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (hi = remainder, lo = quotient), signed or unsigned.
// Latency: accept at cycle N -> out_valid at N+WIDTH+3; zero divisor -> N+1.
// Result held in DONE until out_ready; no accept outside IDLE; flush cancels back to IDLE.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    div_iter_if.slave  dif,
    output logic       busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t        state_q, state_d;
    logic              accept;
    logic              in_ready_s;
    logic              out_valid_s;

    // working registers
    logic              sign_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  quo_q;
    logic [WIDTH-1:0]  dvs_q;
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic [CNT_W-1:0]  cnt_q;

    // result registers
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              dz_q;

    // one restoring step
    logic [WIDTH-1:0]  step_rem;
    logic [WIDTH-1:0]  step_quo;

    // Conditional two's-complement negate, truncated to WIDTH
    function automatic logic [WIDTH-1:0] cneg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign accept = dif.in_valid & in_ready_s & ~flush;

    div_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; flush overrides every non-idle transition
    always_comb begin
        state_d     = state_q;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_s = 1'b1;
                if (accept) begin
                    state_d = (dif.srcb == '0) ? DONE : PREP;
                end
            end
            PREP: begin
                state_d = ITER;
            end
            ITER: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid_s = 1'b1;
                if (dif.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Working datapath: operands land raw at accept, become magnitudes in PREP, iterate in ITER
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q    <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sign_q <= dif.sign;
                        quo_q  <= dif.srca;
                        dvs_q  <= dif.srcb;
                    end
                end
                PREP: begin
                    // quotient sign from both operands, remainder follows the dividend
                    neg_quo_q <= sign_q & (quo_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    neg_rem_q <= sign_q & quo_q[WIDTH-1];
                    quo_q     <= cneg(sign_q & quo_q[WIDTH-1], quo_q);
                    dvs_q     <= cneg(sign_q & dvs_q[WIDTH-1], dvs_q);
                    rem_q     <= '0;
                    cnt_q     <= CNT_W'(WIDTH);
                end
                ITER: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: zero divisor fills at accept, normal path fills in FIX; flush leaves them stale
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            dz_q <= 1'b0;
        end else if (accept) begin
            if (dif.srcb == '0) begin
                hi_q <= dif.srca;
                lo_q <= '1;
                dz_q <= 1'b1;
            end else begin
                dz_q <= 1'b0;
            end
        end else if ((state_q == FIX) && !flush) begin
            lo_q <= cneg(neg_quo_q, quo_q);
            hi_q <= cneg(neg_rem_q, rem_q);
        end
    end

    assign dif.in_ready  = in_ready_s;
    assign dif.out_valid = out_valid_s;
    assign dif.hi        = hi_q;
    assign dif.lo        = lo_q;
    assign dif.div_zero  = dz_q;
    assign busy          = (state_q != IDLE);

endmodule : div_iter

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter at WIDTH=32 and WIDTH=8.
// Reference results come from plain signed/unsigned integer division.
// Exercises latency, backpressure, flush, zero divisor and mid-operation reset.
module tb_div_iter;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy32;
    logic busy8;
    int   total = 0;
    int   bad   = 0;

    div_iter_if #(.WIDTH(32)) b32 ();
    div_iter_if #(.WIDTH(8))  b8 ();

    div_iter #(.WIDTH(32)) u32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .dif   (b32),
        .busy  (busy32)
    );

    div_iter #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .dif   (b8),
        .busy  (busy8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference: truncating integer division, with the zero-divisor convention
    function automatic void ref_div(input int w, input logic s, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] q,
                                    output logic [31:0] r);
        longint m, as, bs, qq, rr;
        m = (longint'(1) << w) - 1;
        if (b == 32'd0) begin
            q = 32'(m);
            r = a;
            return;
        end
        as = longint'({32'b0, a});
        bs = longint'({32'b0, b});
        if (s && a[w-1]) as = as - (longint'(1) << w);
        if (s && b[w-1]) bs = bs - (longint'(1) << w);
        qq = as / bs;
        rr = as % bs;
        q = 32'(qq & m);
        r = 32'(rr & m);
    endfunction

    task automatic drive(input int w, input logic v, input logic s, input logic [31:0] a,
                         input logic [31:0] b);
        if (w == 8) begin
            b8.in_valid = v; b8.sign = s; b8.srca = a[7:0]; b8.srcb = b[7:0];
        end else begin
            b32.in_valid = v; b32.sign = s; b32.srca = a; b32.srcb = b;
        end
    endtask

    task automatic set_ordy(input int w, input logic r);
        if (w == 8) b8.out_ready = r;
        else        b32.out_ready = r;
    endtask

    function automatic logic [31:0] rd_lo(input int w);
        return (w == 8) ? {24'b0, b8.lo} : b32.lo;
    endfunction
    function automatic logic [31:0] rd_hi(input int w);
        return (w == 8) ? {24'b0, b8.hi} : b32.hi;
    endfunction
    function automatic logic rd_ov(input int w);
        return (w == 8) ? b8.out_valid : b32.out_valid;
    endfunction
    function automatic logic rd_ir(input int w);
        return (w == 8) ? b8.in_ready : b32.in_ready;
    endfunction
    function automatic logic rd_busy(input int w);
        return (w == 8) ? busy8 : busy32;
    endfunction
    function automatic logic rd_dz(input int w);
        return (w == 8) ? b8.div_zero : b32.div_zero;
    endfunction

    // One complete transaction: accept, wait for result, check, hold for 'hold' cycles, release
    task automatic run_op(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        logic [31:0] mask, am, bm, q, r;
        int lat, busy_n;
        mask = (w == 8) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        am = a & mask;
        bm = b & mask;
        ref_div(w, s, am, bm, q, r);
        chk({tag, ":in_ready"}, 64'(rd_ir(w)), 64'd1);
        drive(w, 1'b1, s, am, bm);
        @(posedge clk); #1;
        drive(w, 1'b0, ~s, $urandom, $urandom);
        lat = 1;
        busy_n = 0;
        while (!rd_ov(w) && lat < 200) begin
            if (rd_busy(w)) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ":latency"}, 64'(lat), (bm == 32'd0) ? 64'd1 : 64'(w + 3));
        chk({tag, ":busy_cycles"}, 64'(busy_n), 64'(lat - 1));
        chk({tag, ":lo"}, 64'(rd_lo(w)), 64'(q));
        chk({tag, ":hi"}, 64'(rd_hi(w)), 64'(r));
        chk({tag, ":div_zero"}, 64'(rd_dz(w)), (bm == 32'd0) ? 64'd1 : 64'd0);
        chk({tag, ":done_in_ready"}, 64'(rd_ir(w)), 64'd0);
        chk({tag, ":done_busy"}, 64'(rd_busy(w)), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ":hold_valid"}, 64'(rd_ov(w)), 64'd1);
            chk({tag, ":hold_lo"}, 64'(rd_lo(w)), 64'(q));
            chk({tag, ":hold_hi"}, 64'(rd_hi(w)), 64'(r));
            chk({tag, ":hold_in_ready"}, 64'(rd_ir(w)), 64'd0);
        end
        set_ordy(w, 1'b1);
        @(posedge clk); #1;
        set_ordy(w, 1'b0);
        chk({tag, ":rel_valid"}, 64'(rd_ov(w)), 64'd0);
        chk({tag, ":rel_in_ready"}, 64'(rd_ir(w)), 64'd1);
        chk({tag, ":rel_busy"}, 64'(rd_busy(w)), 64'd0);
    endtask

    initial begin
        int w;
        int n;
        logic s;
        logic [31:0] a, b;

        rst = 1'b1;
        flush = 1'b0;
        drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
        set_ordy(32, 1'b0);
        set_ordy(8, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_hi", 64'(b32.hi), 64'd0);
        chk("rst_lo", 64'(b32.lo), 64'd0);
        chk("rst_div_zero", 64'(b32.div_zero), 64'd0);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
        chk("rst_in_ready8", 64'(b8.in_ready), 64'd1);
        rst = 1'b0;

        // directed 32-bit cases
        run_op(32, 1'b0, 32'd7, 32'd2, 0, "u7d2");
        run_op(32, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, "sm7d2");
        run_op(32, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, "s7dm2");
        run_op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "ovf");
        run_op(32, 1'b0, 32'hFFFF_FFFF, 32'h10, 0, "uffd16");
        run_op(32, 1'b1, 32'h1234_5678, 32'd0, 0, "dz32");
        chk("dz32_spec_lo", 64'(b32.lo), 64'hFFFF_FFFF);
        chk("dz32_spec_hi", 64'(b32.hi), 64'h1234_5678);

        // flush in ITER cycle 10
        drive(32, 1'b1, 1'b0, 32'd100, 32'd7);
        @(posedge clk); #1;
        drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_flush_busy", 64'(busy32), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy32), 64'd0);
        chk("flush_in_ready", 64'(b32.in_ready), 64'd1);
        chk("flush_out_valid", 64'(b32.out_valid), 64'd0);

        // flush beats in_valid in IDLE
        drive(32, 1'b1, 1'b0, 32'd5, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("flush_idle_no_accept", 64'(busy32), 64'd0);

        run_op(32, 1'b0, 32'd9, 32'd3, 0, "after_flush");

        // 8-bit instance with backpressure
        run_op(8, 1'b1, 32'h81, 32'h03, 5, "w8_bp");
        chk("w8_spec_lo", 64'(b8.lo), 64'hD6);
        chk("w8_spec_hi", 64'(b8.hi), 64'hFF);
        run_op(8, 1'b1, 32'h80, 32'hFF, 0, "w8_ovf");
        run_op(8, 1'b0, 32'hA5, 32'h00, 0, "w8_dz");

        // flush together with out_ready in DONE drops the result
        drive(8, 1'b1, 1'b0, 32'd200, 32'd7);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
        n = 0;
        while (!b8.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w8_flush_done_reached", 64'(b8.out_valid), 64'd1);
        flush = 1'b1;
        set_ordy(8, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0;
        set_ordy(8, 1'b0);
        chk("w8_flush_done_valid", 64'(b8.out_valid), 64'd0);
        chk("w8_flush_done_busy", 64'(busy8), 64'd0);

        // randomized mix on both widths
        for (int i = 0; i < 24; i++) begin
            w = (i % 2 == 1) ? 8 : 32;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            run_op(w, s, a, b, 0, "rnd");
        end

        // reset mid-operation clears results and returns to IDLE
        run_op(32, 1'b1, 32'h1234_5678, 32'd0, 0, "pre_rst");
        drive(32, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'd3);
        @(posedge clk); #1;
        drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 64'(busy32), 64'd0);
        chk("midrst_in_ready", 64'(b32.in_ready), 64'd1);
        chk("midrst_hi", 64'(b32.hi), 64'd0);
        chk("midrst_lo", 64'(b32.lo), 64'd0);
        chk("midrst_div_zero", 64'(b32.div_zero), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div_iter

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the execute stage. It generalises the fixed 32-bit divider to any WIDTH.
- Adds a valid/ready handshake on both sides, a pipeline-flush cancel, and a divide-by-zero fast path.
- Sits beside the multiplier in ex; its outputs feed the HI/LO write muxes (hi = remainder, lo = quotient).

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)
CNT_W, $clog2(WIDTH+1), iteration counter width (localparam, derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset, sampled on rising clk
flush  in  1  cancel any in-flight or held division (exception/branch-likely squash)
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
srca  in  WIDTH  dividend
srcb  in  WIDTH  divisor
out_valid  out  1  result valid; held until out_ready
out_ready  in  1  consumer takes result
hi  out  WIDTH  remainder
lo  out  WIDTH  quotient
div_zero  out  1  result came from zero divisor; qualified by out_valid
busy  out  1  state != IDLE, used by hazard unit for stall

Behaviour:
- Reset: synchronous, active-high. Clock is clk, reset is rst; both polarity and synchronicity are fixed.
  - State goes to IDLE.
  - out_valid=0, hi=0, lo=0, div_zero=0, busy=0, in_ready=1.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid & in_ready & ~flush; latch sign, srca, srcb.
  - If srcb==0, go to DONE next cycle. Otherwise go to PREP.
- PREP:
  - Take absolute values when sign=1.
  - Record neg_q = sign & (a[MSB]^b[MSB]) and neg_r = sign & a[MSB].
  - Load the partial-remainder register with 0 and the quotient register with |a|.
  - cnt = WIDTH. Go to ITER.
- ITER (exactly WIDTH cycles):
  - Shift {rem,quo} left by 1.
  - Trial-subtract |b| from rem using a WIDTH+1-bit subtractor.
  - If the result is non-negative, rem = difference and quo LSB = 1; else rem is restored and quo LSB = 0.
  - Decrement cnt; at cnt==1, go to FIX.
- FIX:
  - lo = neg_q ? -quo : quo.
  - hi = neg_r ? -rem : rem.
  - Negation is truncated to WIDTH bits. Go to DONE.
- DONE:
  - out_valid=1; hi, lo and div_zero are stable.
  - Stay in DONE until out_ready, then go to IDLE.
  - in_ready=0 in DONE; no same-cycle re-accept.
- Latency:
  - Accept at cycle N gives out_valid at N+WIDTH+3 (N+35 for WIDTH=32).
  - Zero divisor gives out_valid at N+1.
- Zero divisor:
  - lo = all ones; hi = srca unchanged, regardless of sign; div_zero=1.
- Signed overflow (-2^(WIDTH-1) / -1):
  - lo = 0x80..0 (wraps), hi = 0, no flag.
  - This falls out of unsigned magnitudes in WIDTH bits; no special case.
- Flush:
  - In any state other than IDLE, the next state is IDLE and out_valid drops next cycle.
  - hi/lo keep their stale values and must not be consumed.
  - Flush wins over in_valid in IDLE (no accept).
  - Flush together with out_ready in DONE: result is dropped, go to IDLE.
- busy = (state != IDLE), combinational from the state register.
- Reset mid-operation behaves the same as flush, and additionally clears hi/lo/div_zero.
- Inputs are sampled only at accept; srca/srcb may change afterwards.

Decomposition:
- Shared package cpu_defs.svh gets:
  - typedef enum div_state_t {IDLE, PREP, ITER, FIX, DONE}.
  - Struct dp_div_req {sign, srca, srcb}, for the ex-side wiring.
- Natural sub-module: div_step. It is one combinational restoring step taking {rem,quo} and |b| and producing the next {rem,quo}, parametrised by WIDTH. It can later be instantiated 2x for radix-4.
- The FSM, counter and sign fix-up stay in div_iter.

Test Plan:
- Unsigned 7/2 (WIDTH=32, sign=0) -> after 35 cycles, lo=0x00000003, hi=0x00000001, div_zero=0; busy high for 35 cycles.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also signed 7/-2 -> lo=0xFFFFFFFD, hi=0x00000001.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Also unsigned 0xFFFFFFFF/0x00000010 -> lo=0x0FFFFFFF, hi=0xF.
- Divide by zero: srca=0x12345678, srcb=0, sign=1 -> out_valid on next cycle, lo=0xFFFFFFFF, hi=0x12345678, div_zero=1.
- Flush: assert flush at ITER cycle 10 -> busy=0 and in_ready=1 next cycle. A new request 9/3 accepted right after completes normally: lo=3, hi=0.
- Backpressure plus WIDTH=8 instance: hold out_ready=0 for 5 cycles -> out_valid and results stable, in_ready=0. Release -> IDLE. 8-bit signed 0x81/0x03 gives lo=0xD6, hi=0xFF with latency 11 cycles.
